// File: rtl/vram_pkg.sv
// Shared constants, clear-FSM state type and address packing for the VRAM arbiter.
// Optional build macro used elsewhere in this slice: VRAM_VBLANK_LOCK_EN.
package vram_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int PIX_W        = 12;
  localparam int ROW_W        = 9;
  localparam int COL_W        = 10;
  localparam int ADDR_W       = 19;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  // RAM address is the row/col pair concatenated, row in the upper bits
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/vram_if.sv
// Bundle of scan-out, writer, clear-control and RAM-side signals of the VRAM arbiter.
// vga_vblank exists only when VRAM_VBLANK_LOCK_EN is defined.
interface vram_if;
  import vram_pkg::*;

  logic              vga_rdn;
  logic [ROW_W-1:0]  vga_row;
  logic [COL_W-1:0]  vga_col;
  logic [PIX_W-1:0]  vga_data;
`ifdef VRAM_VBLANK_LOCK_EN
  logic              vga_vblank;
`endif

  logic              w0_valid, w1_valid;
  logic              w0_ready, w1_ready;
  logic [ROW_W-1:0]  w0_row, w1_row;
  logic [COL_W-1:0]  w0_col, w1_col;
  logic [PIX_W-1:0]  w0_data, w1_data;

  logic              clr_start;
  logic [PIX_W-1:0]  clr_color;
  logic              clr_busy;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata;

  // arbiter side
  modport slave (
`ifdef VRAM_VBLANK_LOCK_EN
    input  vga_vblank,
`endif
    input  vga_rdn, vga_row, vga_col,
    input  w0_valid, w0_row, w0_col, w0_data,
    input  w1_valid, w1_row, w1_col, w1_data,
    input  clr_start, clr_color, ram_rdata,
    output vga_data, w0_ready, w1_ready, clr_busy,
    output ram_addr, ram_we, ram_wdata
  );

  // client / RAM side
  modport master (
`ifdef VRAM_VBLANK_LOCK_EN
    output vga_vblank,
`endif
    output vga_rdn, vga_row, vga_col,
    output w0_valid, w0_row, w0_col, w0_data,
    output w1_valid, w1_row, w1_col, w1_data,
    output clr_start, clr_color, ram_rdata,
    input  vga_data, w0_ready, w1_ready, clr_busy,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_clear_seq.sv
// Full-screen clear sweeper: latches a colour on start, then writes it to every
// visible pixel in raster order, one pixel per free RAM slot.
module vram_clear_seq
  import vram_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [PIX_W-1:0]  color_i,
  input  logic              slot_free_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]  data_o,
  output logic              busy_o
);
  clr_state_e       state_q, state_d;
  logic [PIX_W-1:0] color_q, color_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             last_col, last_px;

  assign busy_o   = (state_q == SWEEP);
  assign wr_en_o  = busy_o && slot_free_i;
  assign addr_o   = pack_addr(row_q, col_q);
  assign data_o   = color_q;
  assign last_col = (col_q == COL_W'(H_ACTIVE - 1));
  assign last_px  = last_col && (row_q == ROW_W'(V_ACTIVE - 1));

  // next state: start is only honoured in IDLE; pointer advances only on a granted slot
  always_comb begin
    state_d = state_q;
    color_d = color_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SWEEP;
          color_d = color_i;
          row_d   = '0;
          col_d   = '0;
        end
      end
      SWEEP: begin
        if (slot_free_i) begin
          if (last_px) state_d = IDLE;
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, colour latch and sweep pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      color_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: VGA scan-out read > clear sweep > round-robin writers.
// Build option VRAM_VBLANK_LOCK_EN adds vga_vblank and restricts writer 1 to vblank.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic  vga_clk,
  input  logic  rst,
  vram_if.slave vif
);
  logic              rd_slot;
  logic              clr_we, clr_busy;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_data;
  logic              w1_elig, gnt0, gnt1;
  logic [ROW_W-1:0]  sel_row;
  logic [COL_W-1:0]  sel_col;
  logic [PIX_W-1:0]  sel_data;
  logic              in_range;
  logic              rr_last_q, rr_last_d;

  assign rd_slot      = !vif.vga_rdn;
  assign vif.vga_data = vif.ram_rdata;
  assign vif.clr_busy = clr_busy;

  vram_clear_seq #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_clr (
    .clk         (vga_clk),
    .rst         (rst),
    .start_i     (vif.clr_start),
    .color_i     (vif.clr_color),
    .slot_free_i (!rd_slot),
    .wr_en_o     (clr_we),
    .addr_o      (clr_addr),
    .data_o      (clr_data),
    .busy_o      (clr_busy)
  );

`ifdef VRAM_VBLANK_LOCK_EN
  // UI painter only touches the frame while the beam is in vertical blanking
  assign w1_elig = vif.w1_valid && vif.vga_vblank;
`else
  assign w1_elig = vif.w1_valid;
`endif

  // w1 wins when alone, or on a tie when w0 was served last
  assign gnt1     = w1_elig && (!vif.w0_valid || !rr_last_q);
  assign gnt0     = vif.w0_valid && !gnt1;
  assign sel_row  = gnt1 ? vif.w1_row  : vif.w0_row;
  assign sel_col  = gnt1 ? vif.w1_col  : vif.w0_col;
  assign sel_data = gnt1 ? vif.w1_data : vif.w0_data;
  assign in_range = (int'(sel_row) < V_ACTIVE) && (int'(sel_col) < H_ACTIVE);

  // slot owner selection; reset forces the RAM strobe and grants low
  always_comb begin
    vif.ram_addr  = pack_addr(vif.vga_row, vif.vga_col);
    vif.ram_we    = 1'b0;
    vif.ram_wdata = '0;
    vif.w0_ready  = 1'b0;
    vif.w1_ready  = 1'b0;
    rr_last_d     = rr_last_q;
    if (rst) begin
      vif.ram_addr = '0;
    end else if (rd_slot) begin
      // scan-out owns the slot; address already defaulted to the VGA position
    end else if (clr_busy) begin
      vif.ram_addr  = clr_addr;
      vif.ram_we    = clr_we;
      vif.ram_wdata = clr_data;
    end else if (gnt0 || gnt1) begin
      // out-of-range pixels are consumed but never reach the RAM
      vif.w0_ready  = gnt0;
      vif.w1_ready  = gnt1;
      rr_last_d     = gnt1;
      vif.ram_addr  = pack_addr(sel_row, sel_col);
      vif.ram_we    = in_range;
      vif.ram_wdata = sel_data;
    end
  end

  // round-robin history; starts at 1 so w0 takes the first tie
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port 12-bit pixel RAM (512x1024 addressed, 480x640 used) between three clients.
- Clients: the VGA scan-out read, a built-in clear-screen sweeper, and two game-logic pixel writers (note renderer, UI painter).
- Sits between vga_controller and the pixel RAM. Scan-out always wins; writes fill the idle slots.
- Contains a clear-sweep FSM and a round-robin writer arbiter.

Parameters:
- H_ACTIVE, 640, visible columns; writer/clear column bound.
- V_ACTIVE, 480, visible rows; writer/clear row bound.
- PIX_W, 12, pixel width (rrrr_gggg_bbbb).

Ports:
- vga_clk  in  1  pixel clock (25 MHz); sole clock.
- rst  in  1  asynchronous, active-high reset.
- vga_rdn  in  1  scan-out read request, active low (from vga_controller).
- vga_row  in  9  scan-out row address.
- vga_col  in  10  scan-out column address.
- vga_data  out  12  pixel returned to vga_controller d_in.
- w0_valid, w1_valid  in  1  writer request.
- w0_ready, w1_ready  out  1  writer grant; transfer when valid&&ready.
- w0_row, w1_row  in  9  writer row.
- w0_col, w1_col  in  10  writer column.
- w0_data, w1_data  in  12  writer pixel.
- clr_start  in  1  pulse; start a full-screen clear.
- clr_color  in  12  clear colour, sampled on clr_start.
- clr_busy  out  1  clear sweep in progress.
- ram_addr  out  19  {row[8:0], col[9:0]}.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  12  RAM write data.
- ram_rdata  in  12  RAM read data, synchronous, 1-cycle latency.

Behaviour:
- Reset (async, rst=1):
  - FSM = IDLE; clr_busy=0; rr_last=1, so w0 wins the first tie.
  - ram_we, w0_ready and w1_ready forced to 0.
  - ram_addr, ram_wdata = 0.
- vga_data = ram_rdata, combinational pass-through.
  - Read data appears on the cycle after vga_rdn=0 with that address.
- Slot priority each cycle, decided combinationally from the current inputs and registered state:
  1. vga_rdn=0: ram_addr={vga_row,vga_col}, ram_we=0, both writers ready=0, clear stalls.
  2. Else clr_busy=1: clear write at sweep pointer; both writers ready=0.
  3. Else writers, round-robin:
     - Only one valid: it is granted.
     - Both valid: the one not equal to rr_last is granted.
     - rr_last updates to the granted index on transfer.
     - No valid: ram_we=0; ram_addr holds the vga address.
- Writer range check:
  - Granted request with row>=V_ACTIVE or col>=H_ACTIVE: ready=1 (consumed) but ram_we=0, i.e. silently dropped.
  - Dropped requests still update rr_last.
- Clear FSM (IDLE, SWEEP):
  - IDLE & clr_start: latch clr_color; ptr_row=0, ptr_col=0; next SWEEP; clr_busy=1 from the next cycle.
  - In SWEEP, each free slot writes the latched colour at {ptr_row,ptr_col}, then advances the pointer:
    - col wraps at H_ACTIVE-1 to 0 and increments row.
    - The write at (V_ACTIVE-1, H_ACTIVE-1) returns the FSM to IDLE; clr_busy=0 on the next cycle.
  - clr_start while in SWEEP is ignored; the latched colour is unchanged.
  - Minimum clear duration is 307200 write cycles plus any stalls from vga_rdn=0.
- Simultaneous events:
  - clr_start together with a writer request in IDLE: the writer is served this cycle; the sweep begins next cycle.
  - Reset mid-sweep aborts to IDLE; RAM contents are undefined/partial.

Optional Feature:
- Macro: VRAM_VBLANK_LOCK_EN.
- Defined:
  - Adds input port vga_vblank (1 bit, high during vertical blanking).
  - w1 is eligible only when vga_vblank=1; outside vblank w1_ready=0 and w0 sees no contention.
  - Purpose: tear-free UI updates.
- Undefined: no vga_vblank port; w1 is arbitrated exactly like w0.

Decomposition:
- Package vram_pkg:
  - Constants H_ACTIVE_DEF=640, V_ACTIVE_DEF=480, PIX_W=12, ADDR_W=19.
  - Clear-FSM state typedef {IDLE, SWEEP}.
  - Address-pack function {row,col}.
- Sub-module vram_clear_seq:
  - Contents: clear FSM, colour latch, row/col pointer.
  - Interface: start, slot_free, wr_en/addr/data, busy.
  - The top instantiates it and keeps VGA priority and writer round-robin.

Test Plan:
- Reset then vga_rdn=0, row=10, col=20, ram_rdata=0xABC next cycle -> ram_addr=0x02814, ram_we=0; vga_data=0xABC one cycle later; w0/w1_ready=0 throughout the read.
- w0 and w1 both valid in blanking (vga_rdn=1) for 4 cycles -> grants alternate w0,w1,w0,w1; ram_we=1 with the matching addr/data each cycle.
- w0_valid with row=480, col=5 -> w0_ready=1, ram_we=0, no RAM write.
- clr_start, clr_color=0x0F0, vga_rdn=1 throughout -> clr_busy high for exactly 307200 cycles; last write at addr {479,639}; writers' ready=0 while busy.
- During clear, hold vga_rdn=0 for 100 cycles -> pointer frozen; clear finishes 100 cycles later; clr_start pulsed mid-sweep with 0xF00 -> ignored, colour stays 0x0F0.
- Assert rst mid-sweep at (row 3, col 7) -> clr_busy=0 and ram_we=0 immediately (async); a new clr_start restarts from (0,0).
